dmem_responder: RTL and testbench



---
 rtl/dmem_responder_pkg.sv | 15 +
 rtl/dmem_store_buffer.sv | 85 ++++++++
 rtl/dmem_responder.sv | 71 +++++++
 tb/tb_dmem_responder.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder and the pipeline
// registers that feed it.
package dmem_responder_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_SB_DEPTH   = 4;

    // One buffered store, at the default widths used by the pipeline.
    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/dmem_store_buffer.sv
// In-order store buffer: circular FIFO of {addr,data} entries with a
// youngest-match forwarding search for loads.
module dmem_store_buffer
    import dmem_responder_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int SB_DEPTH   = DEF_SB_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [ADDR_WIDTH-1:0]       push_addr,
    input  logic [DATA_WIDTH-1:0]       push_data,
    input  logic                        pop,
    output logic [ADDR_WIDTH-1:0]       head_addr,
    output logic [DATA_WIDTH-1:0]       head_data,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(SB_DEPTH):0]   count,
    input  logic [ADDR_WIDTH-1:0]       lookup_addr,
    output logic                        fwd_hit,
    output logic [DATA_WIDTH-1:0]       fwd_data
);

    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] addr_q [SB_DEPTH];
    logic [DATA_WIDTH-1:0] data_q [SB_DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [PTR_W-1:0]      idx;
    logic                  push_ok;
    logic                  pop_ok;

    // Full/empty come from the registered count, so a full buffer refuses
    // a push even when it pops in the same cycle.
    assign full      = (count == CNT_W'(SB_DEPTH));
    assign empty     = (count == '0);
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;
    assign head_addr = addr_q[head];
    assign head_data = data_q[head];

    // Entry storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            addr_q[tail] <= push_addr;
            data_q[tail] <= push_data;
        end
    end

    // Pointers and occupancy; reset discards every buffered store.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_ok) tail <= tail + 1'b1;
            if (pop_ok)  head <= head + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Walk entries oldest to youngest; the last match seen is the youngest.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int unsigned i = 0; i < SB_DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (addr_q[idx] == lookup_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: buffers core stores, drains them into a
// single-port word array when no load is pending, and serves loads with
// one-cycle latency, forwarding from the store buffer on an address hit.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int SB_DEPTH   = DEF_SB_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ADDR_WIDTH-1:0]       i_addr,
    input  logic                        i_mem_write,
    input  logic [DATA_WIDTH-1:0]       i_write_data,
    input  logic                        i_mem_read,
    output logic [DATA_WIDTH-1:0]       o_read_data,
    output logic                        o_read_valid,
    output logic                        o_sb_full,
    output logic                        o_sb_empty,
    output logic [$clog2(SB_DEPTH):0]   o_sb_count
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  drain;
    logic                  fwd_hit;
    logic [DATA_WIDTH-1:0] fwd_data;

    // Loads own the single array port; drain only in load-free cycles.
    assign drain = !i_mem_read && !o_sb_empty;

    dmem_store_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .SB_DEPTH   (SB_DEPTH)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .push        (i_mem_write),
        .push_addr   (i_addr),
        .push_data   (i_write_data),
        .pop         (drain),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .full        (o_sb_full),
        .empty       (o_sb_empty),
        .count       (o_sb_count),
        .lookup_addr (i_addr),
        .fwd_hit     (fwd_hit),
        .fwd_data    (fwd_data)
    );

    // Drain the oldest buffered store into the array.
    always_ff @(posedge clk) begin
        if (drain) mem[head_addr] <= head_data;
    end

    // Registered load response from pre-edge buffer/array state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_read_data  <= '0;
            o_read_valid <= 1'b0;
        end else begin
            o_read_valid <= i_mem_read;
            if (i_mem_read) o_read_data <= fwd_hit ? fwd_data : mem[i_addr];
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with hand-computed expectations.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  i_addr;
    logic        i_mem_write;
    logic [31:0] i_write_data;
    logic        i_mem_read;
    logic [31:0] o_read_data;
    logic        o_read_valid;
    logic        o_sb_full;
    logic        o_sb_empty;
    logic [2:0]  o_sb_count;

    int tests = 0;
    int fails = 0;

    dmem_responder #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (8),
        .SB_DEPTH   (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_addr       (i_addr),
        .i_mem_write  (i_mem_write),
        .i_write_data (i_write_data),
        .i_mem_read   (i_mem_read),
        .o_read_data  (o_read_data),
        .o_read_valid (o_read_valid),
        .o_sb_full    (o_sb_full),
        .o_sb_empty   (o_sb_empty),
        .o_sb_count   (o_sb_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge; return at the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_load(input string tag, input logic [7:0] a, input logic [31:0] exp);
        i_addr     = a;
        i_mem_read = 1'b1;
        step();
        chk({tag, "_valid"}, 32'(o_read_valid), 32'd1);
        chk({tag, "_data"}, o_read_data, exp);
        i_mem_read = 1'b0;
    endtask

    initial begin
        rst = 1'b1; i_addr = '0; i_mem_write = 1'b0; i_write_data = '0; i_mem_read = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_empty", 32'(o_sb_empty), 32'd1);
        chk("rst_count", 32'(o_sb_count), 32'd0);
        chk("rst_valid", 32'(o_read_valid), 32'd0);
        chk("rst_data", o_read_data, 32'd0);
        chk("rst_full", 32'(o_sb_full), 32'd0);

        // Single store, drained with no loads pending
        i_addr = 8'h10; i_write_data = 32'hDEADBEEF; i_mem_write = 1'b1;
        step();
        i_mem_write = 1'b0;
        chk("st1_count", 32'(o_sb_count), 32'd1);
        chk("st1_empty", 32'(o_sb_empty), 32'd0);
        step();
        chk("st1_drained", 32'(o_sb_count), 32'd0);
        chk("st1_empty2", 32'(o_sb_empty), 32'd1);
        step();
        chk("idle_valid", 32'(o_read_valid), 32'd0);
        do_load("ld10", 8'h10, 32'hDEADBEEF);

        // Async reset mid-cycle clears the response immediately
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(o_read_valid), 32'd0);
        chk("arst_data", o_read_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reads held high: two stores to 0x20, youngest forwarded
        i_mem_read = 1'b1; i_addr = 8'h20;
        i_mem_write = 1'b1; i_write_data = 32'h11;
        step();
        i_write_data = 32'h22;
        step();
        i_mem_write = 1'b0;
        chk("fw_count2", 32'(o_sb_count), 32'd2);
        chk("fw_older", o_read_data, 32'h11);
        step();
        chk("fw_youngest", o_read_data, 32'h22);
        chk("fw_hold_count", 32'(o_sb_count), 32'd2);
        i_mem_read = 1'b0;
        step();
        chk("fw_drain1", 32'(o_sb_count), 32'd1);
        step();
        chk("fw_drain0", 32'(o_sb_count), 32'd0);
        do_load("ld20", 8'h20, 32'h22);

        // Five stores with reads held: fifth waits for a drain slot
        i_mem_read = 1'b1;
        for (int k = 0; k < 4; k++) begin
            i_addr = 8'(8'h40 + k); i_write_data = 32'(32'hA0 + k); i_mem_write = 1'b1;
            step();
        end
        chk("fill_count4", 32'(o_sb_count), 32'd4);
        chk("fill_full", 32'(o_sb_full), 32'd1);
        i_addr = 8'h44; i_write_data = 32'hA4;
        step();
        chk("fill_drop_count", 32'(o_sb_count), 32'd4);
        chk("fill_drop_full", 32'(o_sb_full), 32'd1);
        i_mem_read = 1'b0;
        step();
        chk("fill_nopush_count", 32'(o_sb_count), 32'd3);
        chk("fill_nopush_full", 32'(o_sb_full), 32'd0);
        step();
        i_mem_write = 1'b0;
        chk("fill_pushpop_count", 32'(o_sb_count), 32'd3);
        step(); step(); step();
        chk("fill_drained", 32'(o_sb_count), 32'd0);
        chk("fill_empty", 32'(o_sb_empty), 32'd1);
        do_load("ld40", 8'h40, 32'hA0);
        do_load("ld41", 8'h41, 32'hA1);
        do_load("ld42", 8'h42, 32'hA2);
        do_load("ld43", 8'h43, 32'hA3);
        do_load("ld44", 8'h44, 32'hA4);

        // Same-edge store and load: the load sees the old value
        i_addr = 8'h30; i_write_data = 32'h44; i_mem_write = 1'b1;
        step();
        i_mem_write = 1'b0;
        step();
        chk("se_pre_empty", 32'(o_sb_empty), 32'd1);
        i_addr = 8'h30; i_write_data = 32'h55; i_mem_write = 1'b1; i_mem_read = 1'b1;
        step();
        i_mem_write = 1'b0;
        chk("se_old", o_read_data, 32'h44);
        chk("se_count", 32'(o_sb_count), 32'd1);
        step();
        chk("se_new", o_read_data, 32'h55);
        i_mem_read = 1'b0;
        step();
        chk("se_drained", 32'(o_sb_empty), 32'd1);

        // Reset discards buffered stores
        i_mem_read = 1'b1; i_mem_write = 1'b1;
        i_addr = 8'h30; i_write_data = 32'h99; step();
        i_addr = 8'h10; i_write_data = 32'h98; step();
        i_addr = 8'h20; i_write_data = 32'h97; step();
        i_mem_write = 1'b0; i_mem_read = 1'b0;
        chk("rd_count3", 32'(o_sb_count), 32'd3);
        rst = 1'b1;
        #1;
        chk("rd_count0", 32'(o_sb_count), 32'd0);
        chk("rd_empty", 32'(o_sb_empty), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        do_load("rd_ld30", 8'h30, 32'h55);
        do_load("rd_ld10", 8'h10, 32'hDEADBEEF);
        do_load("rd_ld20", 8'h20, 32'h22);
        step();
        chk("end_valid", 32'(o_read_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
